// File: rtl/mux_select_arbiter_pkg.sv
// +----------------------------------------------------------------------+
// | mux_arb_pkg: shared types and constants for mux_select_arbiter.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package mux_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_OWN0 = 2'd1,
    ARB_OWN1 = 2'd2
  } arb_state_t;

  localparam int MUX_ARB_MAX_HOLD_DEFAULT = 16;
  localparam int MUX_ARB_HOLD_CNT_W       = 8;

  // prio_last names the source served most recently, so a tie goes to the other one.
  function automatic arb_state_t arb_pick(input logic r0, input logic r1, input logic prio_last);
    arb_state_t s;
    s = ARB_IDLE;
    if (r0 && r1)  s = prio_last ? ARB_OWN0 : ARB_OWN1;
    else if (r0)   s = ARB_OWN0;
    else if (r1)   s = ARB_OWN1;
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mux_select_arbiter_if.sv
// +----------------------------------------------------------------------+
// | mux_arb_if: request/beat inputs and grant/select outputs of arbiter. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

interface mux_arb_if;

  logic req0;
  logic req1;
  logic last0;
  logic last1;
  logic beat;
  logic select;
  logic grant0;
  logic grant1;
  logic valid;
  logic timeout;

  modport master (
    output req0, req1, last0, last1, beat,
    input  select, grant0, grant1, valid, timeout
  );

  modport slave (
    input  req0, req1, last0, last1, beat,
    output select, grant0, grant1, valid, timeout
  );

endinterface

`default_nettype wire

// File: rtl/mux_select_arbiter_hold_timer.sv
// +----------------------------------------------------------------------+
// | hold_timer: counts cycles a grant goes without an accepted beat.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module hold_timer
  import mux_arb_pkg::*;
#(
  parameter int MAX_HOLD = MUX_ARB_MAX_HOLD_DEFAULT
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic active_i,
  input  wire logic accept_i,
  output logic      expire_o
);

  localparam logic [MUX_ARB_HOLD_CNT_W-1:0] c_LIMIT = MUX_ARB_HOLD_CNT_W'(MAX_HOLD - 1);

  logic [MUX_ARB_HOLD_CNT_W-1:0] cnt_q;
  logic [MUX_ARB_HOLD_CNT_W-1:0] cnt_d;

  // Expiry fires in the cycle the count would reach MAX_HOLD; that edge releases.
  assign expire_o = active_i && !accept_i && (cnt_q == c_LIMIT);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (!active_i || accept_i || expire_o) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

`default_nettype wire

// File: rtl/mux_select_arbiter.sv
// +----------------------------------------------------------------------+
// | mux_select_arbiter: 2-source round-robin arbiter driving mux select. |
// | Optional watchdog: define MUX_ARB_TIMEOUT_EN.  Revision: 1.0         |
// +----------------------------------------------------------------------+
`default_nettype none

module mux_select_arbiter
  import mux_arb_pkg::*;
#(
  parameter int MAX_HOLD = MUX_ARB_MAX_HOLD_DEFAULT
) (
  input  wire logic clk,
  input  wire logic rst,
  mux_arb_if.slave  bus
);

  arb_state_t state_q, state_d;
  logic       prio_last_q, prio_last_d;
  logic       select_q, select_d;
  logic       grant0_q, grant1_q;
  logic       timeout_q;
  logic       w_valid;
  logic       w_accept;
  logic       w_expire;

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("mux_select_arbiter: MAX_HOLD out of range 2..255");
  end

  assign w_valid  = (grant0_q & bus.req0) | (grant1_q & bus.req1);
  assign w_accept = bus.beat & w_valid;

`ifdef MUX_ARB_TIMEOUT_EN
  hold_timer #(
    .MAX_HOLD (MAX_HOLD)
  ) u_hold_timer (
    .clk      (clk),
    .rst      (rst),
    .active_i ((state_q == ARB_OWN0) || (state_q == ARB_OWN1)),
    .accept_i (w_accept),
    .expire_o (w_expire)
  );
`else
  assign w_expire = 1'b0;
`endif

  // The releasing source is masked out so the other requester wins without a bubble.
  always_comb begin
    state_d     = state_q;
    prio_last_d = prio_last_q;
    case (state_q)
      ARB_IDLE: state_d = arb_pick(bus.req0, bus.req1, prio_last_q);
      ARB_OWN0: begin
        if ((w_accept && bus.last0) || w_expire) begin
          prio_last_d = 1'b0;
          state_d     = arb_pick(1'b0, bus.req1, 1'b0);
        end
      end
      ARB_OWN1: begin
        if ((w_accept && bus.last1) || w_expire) begin
          prio_last_d = 1'b1;
          state_d     = arb_pick(bus.req0, 1'b0, 1'b1);
        end
      end
      default: state_d = ARB_IDLE;
    endcase

    select_d = select_q;
    if (state_d == ARB_OWN0)      select_d = 1'b0;
    else if (state_d == ARB_OWN1) select_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      prio_last_q <= 1'b1;
      select_q    <= 1'b0;
      grant0_q    <= 1'b0;
      grant1_q    <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      prio_last_q <= prio_last_d;
      select_q    <= select_d;
      grant0_q    <= (state_d == ARB_OWN0);
      grant1_q    <= (state_d == ARB_OWN1);
      timeout_q   <= w_expire;
    end
  end

  assign bus.select  = select_q;
  assign bus.grant0  = grant0_q;
  assign bus.grant1  = grant1_q;
  assign bus.valid   = w_valid;
  assign bus.timeout = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_mux_select_arbiter.sv
// +----------------------------------------------------------------------+
// | tb_mux_select_arbiter: directed self-checking bench for the arbiter. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_mux_select_arbiter;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;
  int   owner;

`ifdef MUX_ARB_TIMEOUT_EN
  localparam int c_DROP_CYC = 2;
`else
  localparam int c_DROP_CYC = 5;
`endif

  mux_arb_if bus ();

  mux_select_arbiter #(
    .MAX_HOLD (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic g0, input logic g1,
                         input logic sel, input logic vld, input logic tmo);
    chk({tag, ".grant0"},  bus.grant0,  g0);
    chk({tag, ".grant1"},  bus.grant1,  g1);
    chk({tag, ".select"},  bus.select,  sel);
    chk({tag, ".valid"},   bus.valid,   vld);
    chk({tag, ".timeout"}, bus.timeout, tmo);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst       = 1'b1;
    bus.req0  = 1'b0;
    bus.req1  = 1'b0;
    bus.last0 = 1'b0;
    bus.last1 = 1'b0;
    bus.beat  = 1'b0;

    // Reset: outputs stay low even with a request pending.
    tick();
    bus.req0 = 1'b1;
    tick();
    chk_all("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // Single request: granted one edge after sampling.
    tick();
    chk_all("req0_grant", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    bus.beat = 1'b1; bus.last0 = 1'b1;
    tick();
    bus.beat = 1'b0; bus.last0 = 1'b0; bus.req0 = 1'b0;
    #1;
    chk_all("release_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Fresh reset, then a tie: source 0 first, zero-bubble handover to 1.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    tick();
    chk_all("tie_first", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    bus.beat = 1'b1;
    tick();
    chk("beat1.grant0", bus.grant0, 1'b1);
    tick();
    chk("beat2.grant0", bus.grant0, 1'b1);
    bus.last0 = 1'b1;
    tick();
    chk_all("handover", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);

    // Round robin: single-beat transfers alternate ownership.
    owner = 1;
    for (int i = 0; i < 4; i++) begin
      bus.last0 = (owner == 0);
      bus.last1 = (owner == 1);
      tick();
      owner = 1 - owner;
      chk("rr.grant0", bus.grant0, owner == 0);
      chk("rr.grant1", bus.grant1, owner == 1);
      chk("rr.select", bus.select, owner == 1);
    end
    bus.last0 = 1'b0;
    bus.last1 = 1'b1;
    tick();
    chk_all("to_own0", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    // Owner drops req: grant held, valid low, beat+last ignored.
    bus.req0 = 1'b0; bus.last1 = 1'b0; bus.last0 = 1'b1; bus.beat = 1'b1;
    for (int i = 0; i < c_DROP_CYC; i++) begin
      #1;
      chk("drop.valid_now", bus.valid, 1'b0);
      tick();
      chk_all("drop", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    bus.req0 = 1'b1; bus.last0 = 1'b0;
    #1;
    chk("restore.valid", bus.valid, 1'b1);
    tick();
    bus.beat = 1'b0;
    chk("midbeat.grant0", bus.grant0, 1'b1);

`ifdef MUX_ARB_TIMEOUT_EN
    // Watchdog with MAX_HOLD=4: four silent cycles force release to source 1.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("wd_wait.grant0", bus.grant0, 1'b1);
      chk("wd_wait.timeout", bus.timeout, 1'b0);
    end
    tick();
    chk_all("wd_fire", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    chk("wd_pulse_end", bus.timeout, 1'b0);
`else
    for (int i = 0; i < 100; i++) begin
      tick();
      chk("hold.grant0", bus.grant0, 1'b1);
      chk("hold.timeout", bus.timeout, 1'b0);
    end
`endif

    // Reach OWN1 in either build (a source-0 last beat ends OWN0 if still held).
    bus.beat = 1'b1; bus.last0 = 1'b1;
    tick();
    bus.beat = 1'b0; bus.last0 = 1'b0;
    chk_all("own1", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);

    // Asynchronous reset mid-transfer clears outputs before the next edge.
    #2;
    rst = 1'b1;
    #1;
    chk_all("async_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    chk_all("post_rst_tie", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
